// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipe: load-use bubbles,
// taken-branch squash, dmem freeze, saturating perf counters.
module pipe_hazard_ctrl #(
  parameter int unsigned LU_STALL_CYCLES = 1,
  parameter int unsigned CNT_W           = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             mem_valid,
  input  logic             mem_br_taken,
  input  logic             dmem_busy,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_kill,
  output logic             id_ex_kill,
  output logic             ex_mem_kill,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic {
    RUN      = 1'b0,
    LU_STALL = 1'b1
  } state_t;

  localparam logic [2:0] LU_RELOAD = 3'(LU_STALL_CYCLES - 1);

  state_t           r_state;
  logic [2:0]       r_stall_cnt;
  logic [CNT_W-1:0] r_stall_count;
  logic [CNT_W-1:0] r_flush_count;

  logic w_hz;
  logic w_stall;
  logic w_stall_sat;
  logic w_flush_sat;
  logic w_unused;

  // mem_br_taken arrives already qualified with mem_valid
  assign w_unused = mem_valid;

  assign w_hz = if_id_valid & ex_valid & ex_mem_read
              & (ex_rd != 5'd31)
              & ((id_use_rs1 & (id_rs1 == ex_rd))
               | (id_use_rs2 & (id_rs2 == ex_rd)));

  assign w_stall     = (r_state == LU_STALL) | w_hz;
  assign w_stall_sat = &r_stall_count;
  assign w_flush_sat = &r_flush_count;

  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    id_ex_en    = 1'b1;
    ex_mem_en   = 1'b1;
    mem_wb_en   = 1'b1;
    if_id_kill  = 1'b0;
    id_ex_kill  = 1'b0;
    ex_mem_kill = 1'b0;
    if (!reset) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
      {if_id_kill, id_ex_kill, ex_mem_kill} = '1;
    end else if (dmem_busy) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
    end else if (mem_br_taken) begin
      {if_id_kill, id_ex_kill, ex_mem_kill} = '1;
    end else if (w_stall) begin
      pc_en      = 1'b0;
      if_id_en   = 1'b0;
      id_ex_kill = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= RUN;
      r_stall_cnt   <= '0;
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else if (dmem_busy) begin
      if (!w_stall_sat)
        r_stall_count <= r_stall_count + CNT_W'(1);
    end else if (mem_br_taken) begin
      if (!w_flush_sat)
        r_flush_count <= r_flush_count + CNT_W'(1);
      r_state     <= RUN;
      r_stall_cnt <= '0;
    end else if (r_state == LU_STALL) begin
      if (!w_stall_sat)
        r_stall_count <= r_stall_count + CNT_W'(1);
      r_stall_cnt <= r_stall_cnt - 3'd1;
      if (r_stall_cnt == 3'd1)
        r_state <= RUN;
    end else if (w_hz) begin
      if (!w_stall_sat)
        r_stall_count <= r_stall_count + CNT_W'(1);
      if (LU_STALL_CYCLES > 1) begin
        r_state     <= LU_STALL;
        r_stall_cnt <= LU_RELOAD;
      end
    end
  end

  assign stall_count = r_stall_count;
  assign flush_count = r_flush_count;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: three instances
// (default, 3-bubble load-use, 4-bit counters) on shared inputs.
module tb_pipe_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic       if_id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_use_rs1;
  logic       id_use_rs2;
  logic       ex_valid;
  logic       ex_mem_read;
  logic [4:0] ex_rd;
  logic       mem_valid;
  logic       mem_br_taken;
  logic       dmem_busy;

  logic [7:0]  ctl1, ctl3, ctl4;
  logic [31:0] sc1, fc1, sc3, fc3;
  logic [3:0]  sc4, fc4;

  int n_vec = 0;
  int n_err = 0;

  // {pc,if_id,id_ex,ex_mem,mem_wb en, if_id,id_ex,ex_mem kill}
  localparam logic [7:0] O_RST = 8'b00000_111;
  localparam logic [7:0] O_RUN = 8'b11111_000;
  localparam logic [7:0] O_FRZ = 8'b00000_000;
  localparam logic [7:0] O_FLS = 8'b11111_111;
  localparam logic [7:0] O_STL = 8'b00111_010;

  pipe_hazard_ctrl dut1 (
    .clk(clk), .reset(reset), .if_id_valid(if_id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .mem_valid(mem_valid), .mem_br_taken(mem_br_taken),
    .dmem_busy(dmem_busy),
    .pc_en(ctl1[7]), .if_id_en(ctl1[6]), .id_ex_en(ctl1[5]),
    .ex_mem_en(ctl1[4]), .mem_wb_en(ctl1[3]),
    .if_id_kill(ctl1[2]), .id_ex_kill(ctl1[1]), .ex_mem_kill(ctl1[0]),
    .stall_count(sc1), .flush_count(fc1)
  );

  pipe_hazard_ctrl #(.LU_STALL_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .if_id_valid(if_id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .mem_valid(mem_valid), .mem_br_taken(mem_br_taken),
    .dmem_busy(dmem_busy),
    .pc_en(ctl3[7]), .if_id_en(ctl3[6]), .id_ex_en(ctl3[5]),
    .ex_mem_en(ctl3[4]), .mem_wb_en(ctl3[3]),
    .if_id_kill(ctl3[2]), .id_ex_kill(ctl3[1]), .ex_mem_kill(ctl3[0]),
    .stall_count(sc3), .flush_count(fc3)
  );

  pipe_hazard_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .if_id_valid(if_id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .mem_valid(mem_valid), .mem_br_taken(mem_br_taken),
    .dmem_busy(dmem_busy),
    .pc_en(ctl4[7]), .if_id_en(ctl4[6]), .id_ex_en(ctl4[5]),
    .ex_mem_en(ctl4[4]), .mem_wb_en(ctl4[3]),
    .if_id_kill(ctl4[2]), .id_ex_kill(ctl4[1]), .ex_mem_kill(ctl4[0]),
    .stall_count(sc4), .flush_count(fc4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change at negedge; outputs sampled 1ns later.
  task automatic idle_inputs();
    if_id_valid  = 1'b0;
    id_rs1       = 5'd0;
    id_rs2       = 5'd0;
    id_use_rs1   = 1'b0;
    id_use_rs2   = 1'b0;
    ex_valid     = 1'b0;
    ex_mem_read  = 1'b0;
    ex_rd        = 5'd0;
    mem_valid    = 1'b0;
    mem_br_taken = 1'b0;
    dmem_busy    = 1'b0;
  endtask

  task automatic next_cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    next_cyc();
    reset = 1'b1;
  endtask

  task automatic set_hazard(input logic [4:0] rd, input logic [4:0] rs1,
                            input logic u1, input logic [4:0] rs2,
                            input logic u2);
    if_id_valid = 1'b1;
    ex_valid    = 1'b1;
    mem_valid   = 1'b1;
    ex_mem_read = 1'b1;
    ex_rd       = rd;
    id_rs1      = rs1;
    id_use_rs1  = u1;
    id_rs2      = rs2;
    id_use_rs2  = u2;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (ctl1 !== O_RST || ctl3 !== O_RST || ctl4 !== O_RST) begin
        n_err++;
        $display("FAIL reset_out[%0d]: got %b/%b/%b want %b",
                 i, ctl1, ctl3, ctl4, O_RST);
      end
      next_cyc();
    end
    reset = 1'b1;
    #1;
    n_vec++;
    if (ctl1 !== O_RUN || ctl3 !== O_RUN || ctl4 !== O_RUN) begin
      n_err++;
      $display("FAIL post_reset_out: got %b/%b/%b want %b",
               ctl1, ctl3, ctl4, O_RUN);
    end
    n_vec++;
    if (sc1 !== 32'd0 || fc1 !== 32'd0 || sc3 !== 32'd0 ||
        fc3 !== 32'd0 || sc4 !== 4'd0 || fc4 !== 4'd0) begin
      n_err++;
      $display("FAIL post_reset_cnt: got %0d %0d %0d %0d %0d %0d want 0",
               sc1, fc1, sc3, fc3, sc4, fc4);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    next_cyc();
    set_hazard(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    #1;
    n_vec++;
    if (ctl1 !== O_STL) begin
      n_err++;
      $display("FAIL lu_rs1_out: got %b want %b", ctl1, O_STL);
    end
    next_cyc();
    ex_mem_read = 1'b0;
    #1;
    n_vec++;
    if (ctl1 !== O_RUN || sc1 !== 32'd1) begin
      n_err++;
      $display("FAIL lu_rs1_after: got %b cnt %0d want %b cnt 1",
               ctl1, sc1, O_RUN);
    end
    set_hazard(5'd9, 5'd3, 1'b1, 5'd9, 1'b1);
    #1;
    n_vec++;
    if (ctl1 !== O_STL) begin
      n_err++;
      $display("FAIL lu_rs2_out: got %b want %b", ctl1, O_STL);
    end
    id_use_rs2 = 1'b0;
    #1;
    n_vec++;
    if (ctl1 !== O_RUN) begin
      n_err++;
      $display("FAIL lu_unused_src: got %b want %b", ctl1, O_RUN);
    end
  endtask

  task automatic test_xzr();
    do_reset();
    next_cyc();
    set_hazard(5'd31, 5'd31, 1'b1, 5'd31, 1'b1);
    #1;
    n_vec++;
    if (ctl1 !== O_RUN) begin
      n_err++;
      $display("FAIL xzr_out: got %b want %b", ctl1, O_RUN);
    end
    next_cyc();
    n_vec++;
    if (sc1 !== 32'd0) begin
      n_err++;
      $display("FAIL xzr_cnt: got %0d want 0", sc1);
    end
  endtask

  task automatic test_multi_stall();
    do_reset();
    next_cyc();
    set_hazard(5'd7, 5'd7, 1'b1, 5'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++;
      if (ctl3 !== O_STL) begin
        n_err++;
        $display("FAIL multi_stall[%0d]: got %b want %b", i, ctl3, O_STL);
      end
      next_cyc();
      idle_inputs();
    end
    #1;
    n_vec++;
    if (ctl3 !== O_RUN || sc3 !== 32'd3) begin
      n_err++;
      $display("FAIL multi_stall_end: got %b cnt %0d want %b cnt 3",
               ctl3, sc3, O_RUN);
    end
  endtask

  task automatic test_branch_in_stall();
    do_reset();
    next_cyc();
    set_hazard(5'd4, 5'd4, 1'b1, 5'd0, 1'b0);
    #1;
    n_vec++;
    if (ctl3 !== O_STL) begin
      n_err++;
      $display("FAIL br_stall_1st: got %b want %b", ctl3, O_STL);
    end
    next_cyc();
    idle_inputs();
    mem_br_taken = 1'b1;
    #1;
    n_vec++;
    if (ctl3 !== O_FLS) begin
      n_err++;
      $display("FAIL br_stall_flush: got %b want %b", ctl3, O_FLS);
    end
    next_cyc();
    mem_br_taken = 1'b0;
    #1;
    n_vec++;
    if (ctl3 !== O_RUN || fc3 !== 32'd1 || sc3 !== 32'd1) begin
      n_err++;
      $display("FAIL br_stall_after: got %b f%0d s%0d want %b f1 s1",
               ctl3, fc3, sc3, O_RUN);
    end
    next_cyc();
    n_vec++;
    if (ctl3 !== O_RUN) begin
      n_err++;
      $display("FAIL br_stall_abandon: got %b want %b", ctl3, O_RUN);
    end
  endtask

  task automatic test_freeze_branch();
    do_reset();
    next_cyc();
    dmem_busy    = 1'b1;
    mem_br_taken = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_vec++;
      if (ctl1 !== O_FRZ) begin
        n_err++;
        $display("FAIL freeze[%0d]: got %b want %b", i, ctl1, O_FRZ);
      end
      next_cyc();
    end
    dmem_busy = 1'b0;
    #1;
    n_vec++;
    if (ctl1 !== O_FLS || sc1 !== 32'd4 || fc1 !== 32'd0) begin
      n_err++;
      $display("FAIL freeze_release: got %b s%0d f%0d want %b s4 f0",
               ctl1, sc1, fc1, O_FLS);
    end
    next_cyc();
    mem_br_taken = 1'b0;
    #1;
    n_vec++;
    if (ctl1 !== O_RUN || fc1 !== 32'd1) begin
      n_err++;
      $display("FAIL freeze_flush_cnt: got %b f%0d want %b f1",
               ctl1, fc1, O_RUN);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    next_cyc();
    set_hazard(5'd2, 5'd2, 1'b1, 5'd0, 1'b0);
    mem_br_taken = 1'b1;
    #1;
    n_vec++;
    if (ctl1 !== O_FLS) begin
      n_err++;
      $display("FAIL flush_over_hz: got %b want %b", ctl1, O_FLS);
    end
    do_reset();
    next_cyc();
    set_hazard(5'd8, 5'd8, 1'b1, 5'd0, 1'b0);
    #1;
    next_cyc();
    idle_inputs();
    dmem_busy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_vec++;
      if (ctl3 !== O_FRZ) begin
        n_err++;
        $display("FAIL stall_freeze[%0d]: got %b want %b", i, ctl3, O_FRZ);
      end
      next_cyc();
    end
    dmem_busy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_vec++;
      if (ctl3 !== O_STL) begin
        n_err++;
        $display("FAIL stall_resume[%0d]: got %b want %b", i, ctl3, O_STL);
      end
      next_cyc();
    end
    n_vec++;
    if (ctl3 !== O_RUN || sc3 !== 32'd5) begin
      n_err++;
      $display("FAIL stall_freeze_end: got %b s%0d want %b s5",
               ctl3, sc3, O_RUN);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    next_cyc();
    dmem_busy = 1'b1;
    for (int i = 0; i < 14; i++) next_cyc();
    n_vec++;
    if (sc4 !== 4'd14) begin
      n_err++;
      $display("FAIL sat_mid: got %0d want 14", sc4);
    end
    for (int i = 0; i < 6; i++) next_cyc();
    n_vec++;
    if (sc4 !== 4'd15 || sc1 !== 32'd20) begin
      n_err++;
      $display("FAIL sat_end: got %0d/%0d want 15/20", sc4, sc1);
    end
    dmem_busy = 1'b0;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    #1;
    test_reset();
    test_load_use();
    test_xzr();
    test_multi_stall();
    test_branch_in_stall();
    test_freeze_branch();
    test_back_to_back();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
